fifo_rr_arbiter: RTL and testbench



---
 rtl/fifo_rr_arbiter.sv | 91 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers.
// Optional packet locking (req_last_i, beats of a packet stay together) is enabled by defining ARB_PKT_LOCK_EN.
module fifo_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
`ifdef ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_last_i,
`endif
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic [ID_W-1:0]          grant_id_o
);

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W:0]      cand;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic [ID_W-1:0]    next_ptr;
    logic               load;

`ifdef ARB_PKT_LOCK_EN
    logic               locked;
    logic [ID_W-1:0]    lock_idx;

    // While a packet is open only its owner may compete.
    assign eligible = locked ? (req_valid_i & (NUM_REQ'(1) << lock_idx)) : req_valid_i;
`else
    assign eligible = req_valid_i;
`endif

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && eligible[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr    = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    assign load        = arst_ni && (!data_valid_o || data_ready_i) && win_found;
    assign req_ready_o = load ? (NUM_REQ'(1) << win_idx) : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            grant_id_o   <= '0;
            ptr          <= '0;
`ifdef ARB_PKT_LOCK_EN
            locked       <= 1'b0;
            lock_idx     <= '0;
`endif
        end else if (load) begin
            data_o       <= req_data_i[win_idx*WIDTH +: WIDTH];
            grant_id_o   <= win_idx;
            data_valid_o <= 1'b1;
`ifdef ARB_PKT_LOCK_EN
            if (req_last_i[win_idx]) begin
                locked <= 1'b0;
                ptr    <= next_ptr;
            end else begin
                locked   <= 1'b1;
                lock_idx <= win_idx;
            end
`else
            ptr          <= next_ptr;
`endif
        end else if (data_ready_i) begin
            data_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a queue-free behavioural round-robin model.
module tb_fifo_rr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                     clk_i = 1'b0;
    logic                     arst_ni;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         data_out;
    logic                     data_valid;
    logic                     data_ready;
    logic [ID_W-1:0]          grant_id;
`ifdef ARB_PKT_LOCK_EN
    logic [NUM_REQ-1:0]       req_last = '1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int               m_ptr;
    bit               m_valid;
    int               m_data;
    int               m_id;
    logic [NUM_REQ-1:0] m_accepted;

    always #5 clk_i = ~clk_i;

    fifo_rr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
`ifdef ARB_PKT_LOCK_EN
        .req_last_i   (req_last),
`endif
        .req_ready_o  (req_ready),
        .data_o       (data_out),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .grant_id_o   (grant_id)
    );

    function automatic int model_winner();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int w;
        w = model_winner();
        if (!arst_ni || (m_valid && !data_ready) || w < 0) return 0;
        return 1 << w;
    endfunction

    // Model advance: one beat taken from the winner, or the output drains.
    always @(posedge clk_i or negedge arst_ni) begin
        int w;
        if (!arst_ni) begin
            m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_accepted = '0;
        end else begin
            m_accepted = NUM_REQ'(model_ready());
            w = model_winner();
            if (m_accepted != '0) begin
                m_data  = int'(req_data[w*WIDTH +: WIDTH]);
                m_id    = w;
                m_valid = 1;
                m_ptr   = (w + 1) % NUM_REQ;
            end else if (data_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic check1(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        check1("model_ready", int'(req_ready), model_ready());
        check1("model_valid", int'(data_valid), int'(m_valid));
        check1("model_data",  int'(data_out), m_data);
        check1("model_id",    int'(grant_id), m_id);
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*WIDTH-1:0] d,
                                 input logic rdy);
        req_valid  = v;
        req_data   = d;
        data_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_ready, input int exp_valid,
                               input int exp_data, input int exp_id);
        check1({name, "_ready"}, int'(req_ready), exp_ready);
        check1({name, "_valid"}, int'(data_valid), exp_valid);
        check1({name, "_data"},  int'(data_out), exp_data);
        check1({name, "_id"},    int'(grant_id), exp_id);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [NUM_REQ*WIDTH-1:0] all_d;
        logic [NUM_REQ-1:0]       v;
        logic [NUM_REQ*WIDTH-1:0] d;
        all_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        arst_ni = 1'b0;
        applyStimulus('0, '0, 1'b0);
        checkOutput("reset", 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        arst_ni = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus('0, '0, 1'b1);
            checkOutput("idle", 0, 0, 0, 0);
            tick();
        end

        // Everyone contends: grants rotate 0,1,2,3 at one beat per cycle
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, all_d, 1'b1);
            if (k == 0) checkOutput("contend", 1, 0, 0, 0);
            else        checkOutput("contend", 1 << (k % 4), 1, 'hA0 + (k - 1) % 4, (k - 1) % 4);
            tick();
        end
        applyStimulus('0, '0, 1'b1);
        checkOutput("contend_last", 0, 1, 'hA3, 3);
        tick();

        // Backpressure on a single beat from requester 2
        applyStimulus(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b0);
        checkOutput("bp_load", 4'b0100, 0, 'hA3, 3);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_stall", 0, 1, 'h5C, 2);
            tick();
        end
        applyStimulus(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b1);
        checkOutput("bp_release", 4'b0100, 1, 'h5C, 2);
        tick();
        applyStimulus('0, '0, 1'b1);
        checkOutput("bp_drain", 0, 1, 'h5C, 2);
        tick();
        checkOutput("bp_empty", 0, 0, 'h5C, 2);

        // Pointer now 3; only requesters 1 and 3 are valid
        d = {8'h33, 8'h00, 8'h11, 8'h00};
        applyStimulus(4'b1010, d, 1'b1);
        checkOutput("wrap0", 4'b1000, 0, 'h5C, 2);
        tick();
        checkOutput("wrap1", 4'b0010, 1, 'h33, 3);
        tick();
        checkOutput("wrap2", 4'b1000, 1, 'h11, 1);
        tick();
        applyStimulus('0, '0, 1'b1);
        checkOutput("wrap3", 0, 1, 'h33, 3);
        tick();

        // Reset while a beat is held and ptr=2
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00}, 1'b0);
        checkOutput("mid_load", 4'b0010, 0, 'h33, 3);
        tick();
        checkOutput("mid_held", 0, 1, 'h77, 1);
        arst_ni = 1'b0;
        #1;
        checkOutput("mid_reset", 0, 0, 0, 0);
        tick();
        arst_ni = 1'b1;
        applyStimulus(4'b1111, all_d, 1'b1);
        checkOutput("post_reset", 1, 0, 0, 0);
        tick();
        checkOutput("post_reset_grant", 2, 1, 'hA0, 0);
        tick();

        // Randomized traffic; requesters hold each beat until accepted
        v = '0;
        d = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!v[i] || m_accepted[i]) begin
                    v[i] = ($urandom_range(0, 99) < 55);
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            applyStimulus(v, d, $urandom_range(0, 99) < 70);
            if (c % 700 == 350) begin
                arst_ni = 1'b0;
                v = '0;
                tick();
                arst_ni = 1'b1;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
